// File: rtl/minmax_pkg.sv
// Shared definitions for the min/max sequencer: FSM states, comparator
// result bit positions, reset constants and the index-width helper.
package minmax_pkg;

   localparam int unsigned DW = 8;

   // One-hot comparator result bit positions
   localparam int unsigned R_GT = 2;
   localparam int unsigned R_EQ = 1;
   localparam int unsigned R_LT = 0;

   localparam logic [DW-1:0] RST_DATA = '0;
   localparam logic [2:0]    RST_R    = 3'b000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_IN,
      S_CMP_MAX,
      S_CMP_MIN,
      S_UPD_MIN,
      S_DONE
   } state_t;

   // Index/counter width, never narrower than one bit
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/minmax_sequencer_if.sv
// Sample input stream: valid/ready handshake carrying one 8-bit sample.
//   InValid : producer has a sample on InData
//   InData  : unsigned sample
//   InReady : consumer accepts the sample this cycle
interface minmax_sequencer_if;
   import minmax_pkg::*;

   logic          InValid;
   logic [DW-1:0] InData;
   logic          InReady;

   modport master (output InValid, InData, input InReady);
   modport slave  (input InValid, InData, output InReady);

endinterface

// File: rtl/minmax_sequencer_cmp_unit.sv
// Registered three-way unsigned comparator, one-hot GT/EQ/LT, one-cycle latency.
//   Clk, nReset : clock, async active-low reset (R resets to 000)
//   A, B        : operands
//   R           : {GT, EQ, LT} of the previous cycle's operands
module cmp_unit
   import minmax_pkg::*;
(
   input  logic          Clk,
   input  logic          nReset,
   input  logic [DW-1:0] A,
   input  logic [DW-1:0] B,
   output logic [2:0]    R
);

   logic [2:0] r_d;

   // Compare
   always_comb begin
      r_d = '0;
      if (A > B)      r_d[R_GT] = 1'b1;
      else if (A < B) r_d[R_LT] = 1'b1;
      else            r_d[R_EQ] = 1'b1;
   end

   // Result register
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) R <= RST_R;
      else         R <= r_d;
   end

endmodule

// File: rtl/minmax_sequencer.sv
// Frame-based running max/min finder sharing one registered comparator
// between the max and min tests of each sample.
//   Clk, nReset    : clock, async active-low reset
//   Start          : begin a frame (only honoured in IDLE)
//   in_if (slave)  : sample stream InValid/InData/InReady
//   Busy           : frame in progress
//   Done           : one-cycle pulse, results final
//   MaxOut, MaxIdx : largest sample and its first index
//   MinOut, MinIdx : smallest sample and its first index
module minmax_sequencer
   import minmax_pkg::*;
#(
   parameter  int unsigned N_SAMPLES = 8,
   localparam int unsigned IW        = idx_width(N_SAMPLES)
)(
   input  logic                Clk,
   input  logic                nReset,
   input  logic                Start,
   minmax_sequencer_if.slave   in_if,
   output logic                Busy,
   output logic                Done,
   output logic [DW-1:0]       MaxOut,
   output logic [DW-1:0]       MinOut,
   output logic [IW-1:0]       MaxIdx,
   output logic [IW-1:0]       MinIdx
);

   localparam logic [IW-1:0] LAST_IDX = IW'(N_SAMPLES - 1);

   state_t          state_q, state_d;
   logic [IW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [DW-1:0]   sample_q, sample_d;
   logic [DW-1:0]   max_d, min_d;
   logic [IW-1:0]   max_idx_d, min_idx_d;
   logic [DW-1:0]   cmp_a, cmp_b;
   logic [2:0]      cmp_r;

   cmp_unit u_cmp (
      .Clk    (Clk),
      .nReset (nReset),
      .A      (cmp_a),
      .B      (cmp_b),
      .R      (cmp_r)
   );

   // Next-state, datapath and comparator operand selection
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      sample_d  = sample_q;
      max_d     = MaxOut;
      min_d     = MinOut;
      max_idx_d = MaxIdx;
      min_idx_d = MinIdx;
      cmp_a     = '0;
      cmp_b     = '0;

      case (state_q)
         S_IDLE: begin
            // Results hold after Done until a new frame is actually started
            if (Start) begin
               state_d   = S_WAIT_IN;
               cnt_d     = '0;
               max_d     = RST_DATA;
               min_d     = RST_DATA;
               max_idx_d = '0;
               min_idx_d = '0;
            end
         end

         S_WAIT_IN: begin
            if (in_if.InValid && in_if.InReady) begin
               sample_d = in_if.InData;
               idx_d    = cnt_q;
               if (cnt_q == '0) begin
                  // First sample seeds both extremes without a compare
                  max_d     = in_if.InData;
                  min_d     = in_if.InData;
                  max_idx_d = '0;
                  min_idx_d = '0;
                  if (N_SAMPLES == 1) state_d = S_DONE;
                  else                cnt_d   = cnt_q + IW'(1);
               end else begin
                  state_d = S_CMP_MAX;
               end
            end
         end

         S_CMP_MAX: begin
            cmp_a   = sample_q;
            cmp_b   = MaxOut;
            state_d = S_CMP_MIN;
         end

         S_CMP_MIN: begin
            // Strict GT keeps the earliest index on ties
            if (cmp_r[R_GT] && !cmp_r[R_EQ]) begin
               max_d     = sample_q;
               max_idx_d = idx_q;
            end
            cmp_a   = sample_q;
            cmp_b   = MinOut;
            state_d = S_UPD_MIN;
         end

         S_UPD_MIN: begin
            if (cmp_r[R_LT] && !cmp_r[R_EQ]) begin
               min_d     = sample_q;
               min_idx_d = idx_q;
            end
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               cnt_d   = cnt_q + IW'(1);
               state_d = S_WAIT_IN;
            end
         end

         S_DONE:  state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

   // State, datapath and registered status outputs
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         idx_q         <= '0;
         sample_q      <= RST_DATA;
         MaxOut        <= RST_DATA;
         MinOut        <= RST_DATA;
         MaxIdx        <= '0;
         MinIdx        <= '0;
         in_if.InReady <= 1'b0;
         Busy          <= 1'b0;
         Done          <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         sample_q      <= sample_d;
         MaxOut        <= max_d;
         MinOut        <= min_d;
         MaxIdx        <= max_idx_d;
         MinIdx        <= min_idx_d;
         in_if.InReady <= (state_d == S_WAIT_IN);
         Busy          <= (state_d == S_WAIT_IN) || (state_d == S_CMP_MAX) ||
                          (state_d == S_CMP_MIN) || (state_d == S_UPD_MIN);
         Done          <= (state_d == S_DONE);
      end
   end

endmodule
